park_occupancy_counter: RTL and testbench
=========================================

Name: park_occupancy_counter

Overview:
- Upstream stage of the 7-segment display path in the smart-park design.
- Samples asynchronous car-entry and car-exit sensors, synchronises and edge-detects them, and keeps occupied and free space counts as two-digit BCD.
- Each 4-bit digit output drives one seg7 decoder instance directly (bit 3 -> c3 … bit 0 -> c0).
- Flags full/empty and rejects illegal events.

Parameters:
- CAPACITY, 20, total parking spaces; legal range 1..99. Reset value of the free count.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- car_in_sensor  in  1  async level from entry sensor; high while a car is present
- car_out_sensor  in  1  async level from exit sensor; high while a car is present
- occ_tens  out  4  occupied count, tens digit, BCD 0..9
- occ_ones  out  4  occupied count, ones digit, BCD 0..9
- free_tens  out  4  free count, tens digit, BCD
- free_ones  out  4  free count, ones digit, BCD
- full  out  1  occupied == CAPACITY
- empty  out  1  occupied == 0
- entry_reject  out  1  one-cycle pulse: entry event while full
- exit_error  out  1  one-cycle pulse: exit event while empty

Behaviour:
- Interface (decided): one clock, clk; reset is asynchronous and active-high, port reset.
- Reset values, applied immediately on assertion, independent of clk:
  - occ = 00
  - free = CAPACITY in BCD (20 -> tens 2, ones 0)
  - full = (CAPACITY==0) = 0; empty = 1
  - entry_reject = 0; exit_error = 0
  - all synchroniser and edge flops = 0
- Synchroniser, per sensor: 3-flop chain s1 <= sensor, s2 <= s1, s3 <= s2. Event = s2 & ~s3, true for exactly one cycle per rising edge of the sensor.
- Latency: sensor rises before edge k -> event true in the cycle after k+1 -> counts, flags and pulses update at edge k+2.
- A sensor held high for any number of cycles produces exactly one event. Re-arming requires the sensor to go low.
- Update rules at each edge (ev_in, ev_out):
  - neither: hold.
  - ev_in only, not full: occ += 1, free -= 1.
  - ev_in only, full: no count change; entry_reject = 1 for one cycle.
  - ev_out only, not empty: occ -= 1, free += 1.
  - ev_out only, empty: no count change; exit_error = 1 for one cycle.
  - both in the same cycle: hold counts; no pulses, whatever the full/empty state.
- BCD arithmetic:
  - Increment: ones 9 -> 0 with tens += 1.
  - Decrement: ones 0 -> 9 with tens -= 1.
  - Never wraps past 00 or 99; the guards above make that unreachable.
  - Digits 10..15 never appear on any output.
- Invariant: occ + free == CAPACITY (decimal) at all times after reset.
- full and empty are registered and updated on the same edge as the counts. They never both assert for CAPACITY >= 1.
- Pulses are registered and deassert on the following edge unless a new illegal event occurs.
- Reset mid-operation: asynchronous clear to the reset values. A sensor held high through reset release produces one event after release (s3 = 0 after reset).

Decomposition:
- Package park_pkg holds:
  - default CAPACITY
  - BCD digit width (4)
  - constants BCD_ZERO and BCD_NINE
  - a function converting 0..99 to the two-digit BCD reset value
- Sub-module bcd_updown2: two-digit BCD counter with inc, dec, async reset and a parameterised reset value. Instantiated twice: occupied (reset 00) and free (reset CAPACITY).
- Synchroniser and edge detect stay inline.

Test Plan:
- Reset check: assert reset mid-cycle -> outputs clear immediately: occ 0/0, free 2/0, empty 1, full 0, both pulses 0.
- Single entry: car_in_sensor high for 6 cycles -> occ 0/1 and free 1/9 appear exactly 2 edges after first sampling; count increments exactly once; empty drops to 0 on the same edge.
- BCD carry: 10 separate entry pulses -> occ 1/0, free 1/0. Then 1 exit -> occ 0/9, free 1/1.
- Full and reject: 20 entries -> occ 2/0, free 0/0, full 1. 21st entry -> entry_reject high for exactly one cycle; occ stays 2/0.
- Exit when empty: from reset, one exit -> exit_error one-cycle pulse; occ stays 0/0, empty stays 1.
- Simultaneous events: at occ 0/5, both sensors rise in the same cycle -> occ stays 0/5, no pulses. At full, both rise -> occ stays 2/0, no entry_reject.

Source files
------------

// File: rtl/park_pkg.sv
// rtl/park_pkg.sv - shared constants, BCD types and helpers for the parking occupancy counter
//
// Purpose: default capacity, BCD digit width and digit constants, the packed
// two-digit BCD type and a constant function that turns 0..99 into that type
// (used to build counter reset values at elaboration time).
// Ports: none (package).

package park_pkg;

  localparam int DEFAULT_CAPACITY = 20;
  localparam int BCD_W            = 4;

  localparam logic [BCD_W-1:0] BCD_ZERO = 4'd0;
  localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;

  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
  } bcd2_t;

  // Callers keep v within 0..99; larger values would not fit two digits.
  function automatic bcd2_t to_bcd2(input int unsigned v);
    bcd2_t r;
    r.tens = BCD_W'(v / 10);
    r.ones = BCD_W'(v % 10);
    return r;
  endfunction

endpackage

// File: rtl/bcd_updown2.sv
// rtl/bcd_updown2.sv - two-digit BCD up/down counter with asynchronous reset
//
// Purpose: holds a value 00..99 as two BCD digits. One step up on inc_i, one
// step down on dec_i; both or neither asserted holds the value. The counter
// saturates at 99 and 00 so no out-of-range digit can ever be produced.
// Ports:
//   clk_i   - clock, state updates on rising edge
//   rst_i   - asynchronous active-high reset to RESET_VAL
//   inc_i   - add one this cycle
//   dec_i   - subtract one this cycle
//   tens_o  - tens digit, BCD 0..9
//   ones_o  - ones digit, BCD 0..9

module bcd_updown2
  import park_pkg::*;
#(
  parameter bcd2_t RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [BCD_W-1:0] tens_o,
  output logic [BCD_W-1:0] ones_o
);

  logic [BCD_W-1:0] tens_q, tens_d;
  logic [BCD_W-1:0] ones_q, ones_d;

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (inc_i && !dec_i) begin
      if (ones_q == BCD_NINE) begin
        // Carry into tens; at 99 the value simply holds.
        if (tens_q != BCD_NINE) begin
          ones_d = BCD_ZERO;
          tens_d = tens_q + 4'd1;
        end
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end else if (dec_i && !inc_i) begin
      if (ones_q == BCD_ZERO) begin
        // Borrow from tens; at 00 the value simply holds.
        if (tens_q != BCD_ZERO) begin
          ones_d = BCD_NINE;
          tens_d = tens_q - 4'd1;
        end
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tens_q <= RESET_VAL.tens;
      ones_q <= RESET_VAL.ones;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens_o = tens_q;
  assign ones_o = ones_q;

endmodule

// File: rtl/park_occupancy_counter.sv
// rtl/park_occupancy_counter.sv - synchronised entry/exit sensing with BCD occupied/free counts
//
// Purpose: samples the asynchronous entry and exit sensors through a 3-flop
// chain each, turns each rising edge into a single-cycle event, and keeps the
// occupied and free counts as two BCD digits each. Flags full/empty and
// pulses on illegal events (entry while full, exit while empty).
// Ports:
//   clk            - system clock, rising edge
//   reset          - asynchronous active-high reset
//   car_in_sensor  - async level, high while a car is at the entry
//   car_out_sensor - async level, high while a car is at the exit
//   occ_tens/ones  - occupied count, BCD digits
//   free_tens/ones - free count, BCD digits
//   full, empty    - occupied == CAPACITY / occupied == 0 (registered)
//   entry_reject   - one-cycle pulse, entry event while full
//   exit_error     - one-cycle pulse, exit event while empty
// CAPACITY must lie in 1..99.

module park_occupancy_counter
  import park_pkg::*;
#(
  parameter int CAPACITY = DEFAULT_CAPACITY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             car_in_sensor,
  input  logic             car_out_sensor,
  output logic [BCD_W-1:0] occ_tens,
  output logic [BCD_W-1:0] occ_ones,
  output logic [BCD_W-1:0] free_tens,
  output logic [BCD_W-1:0] free_ones,
  output logic             full,
  output logic             empty,
  output logic             entry_reject,
  output logic             exit_error
);

  localparam logic [6:0] CAP7          = 7'(CAPACITY);
  localparam logic       FULL_AT_RESET = (CAPACITY == 0);

  // Synchroniser chains: s1 is the metastability stage, s2/s3 feed the edge detector.
  logic in_s1_q, in_s2_q, in_s3_q;
  logic out_s1_q, out_s2_q, out_s3_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_s1_q  <= 1'b0;
      in_s2_q  <= 1'b0;
      in_s3_q  <= 1'b0;
      out_s1_q <= 1'b0;
      out_s2_q <= 1'b0;
      out_s3_q <= 1'b0;
    end else begin
      in_s1_q  <= car_in_sensor;
      in_s2_q  <= in_s1_q;
      in_s3_q  <= in_s2_q;
      out_s1_q <= car_out_sensor;
      out_s2_q <= out_s1_q;
      out_s3_q <= out_s2_q;
    end
  end

  logic ev_in, ev_out;
  assign ev_in  = in_s2_q & ~in_s3_q;
  assign ev_out = out_s2_q & ~out_s3_q;

  logic full_q, full_d;
  logic empty_q, empty_d;
  logic entry_reject_q, entry_reject_d;
  logic exit_error_q, exit_error_d;

  // Simultaneous entry and exit cancel: no count change and no pulse.
  logic do_inc, do_dec;
  assign do_inc = ev_in & ~ev_out & ~full_q;
  assign do_dec = ev_out & ~ev_in & ~empty_q;

  logic [BCD_W-1:0] occ_tens_w, occ_ones_w;
  logic [BCD_W-1:0] free_tens_w, free_ones_w;

  bcd_updown2 #(
    .RESET_VAL(to_bcd2(0))
  ) u_occ (
    .clk_i  (clk),
    .rst_i  (reset),
    .inc_i  (do_inc),
    .dec_i  (do_dec),
    .tens_o (occ_tens_w),
    .ones_o (occ_ones_w)
  );

  // Free count moves opposite to occupied so the two always sum to CAPACITY.
  bcd_updown2 #(
    .RESET_VAL(to_bcd2(CAPACITY))
  ) u_free (
    .clk_i  (clk),
    .rst_i  (reset),
    .inc_i  (do_dec),
    .dec_i  (do_inc),
    .tens_o (free_tens_w),
    .ones_o (free_ones_w)
  );

  // Binary view of the current occupancy, used only to predict the flags so
  // they land on the same edge as the counts.
  logic [6:0] occ_bin;
  assign occ_bin = ({3'b000, occ_tens_w} * 7'd10) + {3'b000, occ_ones_w};

  always_comb begin
    full_d         = full_q;
    empty_d        = empty_q;
    entry_reject_d = 1'b0;
    exit_error_d   = 1'b0;
    if (do_inc) begin
      full_d  = (occ_bin == (CAP7 - 7'd1));
      empty_d = 1'b0;
    end else if (do_dec) begin
      full_d  = 1'b0;
      empty_d = (occ_bin == 7'd1);
    end
    if (ev_in && !ev_out && full_q) begin
      entry_reject_d = 1'b1;
    end
    if (ev_out && !ev_in && empty_q) begin
      exit_error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q         <= FULL_AT_RESET;
      empty_q        <= 1'b1;
      entry_reject_q <= 1'b0;
      exit_error_q   <= 1'b0;
    end else begin
      full_q         <= full_d;
      empty_q        <= empty_d;
      entry_reject_q <= entry_reject_d;
      exit_error_q   <= exit_error_d;
    end
  end

  assign occ_tens     = occ_tens_w;
  assign occ_ones     = occ_ones_w;
  assign free_tens    = free_tens_w;
  assign free_ones    = free_ones_w;
  assign full         = full_q;
  assign empty        = empty_q;
  assign entry_reject = entry_reject_q;
  assign exit_error   = exit_error_q;

endmodule

// File: tb/tb_park_occupancy_counter.sv
// tb/tb_park_occupancy_counter.sv - self-checking bench for park_occupancy_counter

module tb_park_occupancy_counter;

  localparam int CAP = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       car_in_sensor;
  logic       car_out_sensor;
  logic [3:0] occ_tens, occ_ones, free_tens, free_ones;
  logic       full, empty, entry_reject, exit_error;

  int tests = 0;
  int fails = 0;

  park_occupancy_counter #(.CAPACITY(CAP)) dut (
    .clk            (clk),
    .reset          (reset),
    .car_in_sensor  (car_in_sensor),
    .car_out_sensor (car_out_sensor),
    .occ_tens       (occ_tens),
    .occ_ones       (occ_ones),
    .free_tens      (free_tens),
    .free_ones      (free_ones),
    .full           (full),
    .empty          (empty),
    .entry_reject   (entry_reject),
    .exit_error     (exit_error)
  );

  always #5 clk = ~clk;

  // Reference model: occupancy as a plain integer. A sensor rise seen at edge
  // k takes effect at edge k+2, modelled as a two-deep delay of rise flags.
  int m_occ;
  bit m_rej, m_err;
  bit prev_in, prev_out;
  bit in_d1, in_d2, out_d1, out_d2;

  task automatic model_reset();
    m_occ = 0;
    m_rej = 0;
    m_err = 0;
    prev_in = 0;
    prev_out = 0;
    in_d1 = 0;
    in_d2 = 0;
    out_d1 = 0;
    out_d2 = 0;
  endtask

  task automatic model_edge(input bit si, input bit so);
    bit ei;
    bit eo;
    ei = in_d2;
    eo = out_d2;
    m_rej = 0;
    m_err = 0;
    if (ei && !eo) begin
      if (m_occ == CAP) m_rej = 1;
      else m_occ = m_occ + 1;
    end else if (eo && !ei) begin
      if (m_occ == 0) m_err = 1;
      else m_occ = m_occ - 1;
    end
    in_d2 = in_d1;
    in_d1 = si & ~prev_in;
    prev_in = si;
    out_d2 = out_d1;
    out_d1 = so & ~prev_out;
    prev_out = so;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("occ_tens", {4'd0, occ_tens}, 8'(m_occ / 10));
    chk("occ_ones", {4'd0, occ_ones}, 8'(m_occ % 10));
    chk("free_tens", {4'd0, free_tens}, 8'((CAP - m_occ) / 10));
    chk("free_ones", {4'd0, free_ones}, 8'((CAP - m_occ) % 10));
    chk("full", {7'd0, full}, {7'd0, m_occ == CAP});
    chk("empty", {7'd0, empty}, {7'd0, m_occ == 0});
    chk("entry_reject", {7'd0, entry_reject}, {7'd0, m_rej});
    chk("exit_error", {7'd0, exit_error}, {7'd0, m_err});
  endtask

  // Called at a negedge: drive, clock once, compare at the next negedge.
  task automatic cycle(input bit si, input bit so, input int n);
    repeat (n) begin
      car_in_sensor = si;
      car_out_sensor = so;
      @(posedge clk);
      model_edge(si, so);
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic ent();
    cycle(1, 0, 1);
    cycle(0, 0, 1);
  endtask

  task automatic ext();
    cycle(0, 1, 1);
    cycle(0, 0, 1);
  endtask

  // Asynchronous reset asserted between edges and checked before any edge.
  task automatic do_reset(input bit si);
    car_in_sensor = si;
    car_out_sensor = 0;
    #2 reset = 1;
    model_reset();
    #1 check_all();
    @(negedge clk);
    reset = 0;
    check_all();
  endtask

  initial begin
    reset = 1;
    car_in_sensor = 0;
    car_out_sensor = 0;
    model_reset();
    @(negedge clk);
    check_all();
    @(negedge clk);
    reset = 0;
    check_all();

    // Single long entry: one increment, two-edge latency, empty drops with it.
    cycle(1, 0, 6);
    cycle(0, 0, 3);
    chk("single_entry_occ", {occ_tens, occ_ones}, 8'h01);
    chk("single_entry_free", {free_tens, free_ones}, 8'h19);

    // Mid-cycle asynchronous reset.
    do_reset(0);

    // BCD carry then borrow.
    repeat (10) ent();
    cycle(0, 0, 3);
    chk("carry_occ", {occ_tens, occ_ones}, 8'h10);
    chk("carry_free", {free_tens, free_ones}, 8'h10);
    ext();
    cycle(0, 0, 3);
    chk("borrow_occ", {occ_tens, occ_ones}, 8'h09);
    chk("borrow_free", {free_tens, free_ones}, 8'h11);

    // Exit while empty.
    do_reset(0);
    ext();
    cycle(0, 0, 3);

    // Simultaneous events at occupancy 5.
    repeat (5) ent();
    cycle(0, 0, 3);
    cycle(1, 1, 1);
    cycle(0, 0, 4);
    chk("simul_occ", {occ_tens, occ_ones}, 8'h05);

    // Fill, then a rejected entry, then simultaneous events while full.
    repeat (15) ent();
    cycle(0, 0, 3);
    chk("full_flag", {7'd0, full}, 8'd1);
    ent();
    cycle(0, 0, 3);
    cycle(1, 1, 1);
    cycle(0, 0, 4);
    chk("full_occ", {occ_tens, occ_ones}, 8'h20);

    // Entry sensor held high through reset release: exactly one event.
    do_reset(1);
    cycle(1, 0, 5);
    cycle(0, 0, 3);

    // Randomised traffic in three regimes.
    for (int ph = 0; ph < 3; ph++) begin
      int pi;
      int po;
      pi = (ph == 0) ? 40 : (ph == 1) ? 10 : 30;
      po = (ph == 0) ? 10 : (ph == 1) ? 40 : 30;
      for (int i = 0; i < 600; i++) begin
        cycle($urandom_range(0, 99) < pi, $urandom_range(0, 99) < po, 1);
      end
    end
    cycle(0, 0, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
